// File: rtl/bg_scroll_level_ctrl_if.sv
// Frame-sequencer bus between game control and the background/road drawing blocks.
// The master drives the per-frame controls; the slave returns scroll and level status.
interface bg_scroll_level_ctrl_if;
  logic        startOfFrame;
  logic        gameStart;
  logic        crash;
  logic [2:0]  speed;
  logic [10:0] scrollY;
  logic [15:0] distance;
  logic [1:0]  levelNum;
  logic        newLevel;
  logic        inTransition;
  logic        levelDone;
  logic        gameFinished;

  modport master (
    output startOfFrame,
    output gameStart,
    output crash,
    output speed,
    input  scrollY,
    input  distance,
    input  levelNum,
    input  newLevel,
    input  inTransition,
    input  levelDone,
    input  gameFinished
  );

  modport slave (
    input  startOfFrame,
    input  gameStart,
    input  crash,
    input  speed,
    output scrollY,
    output distance,
    output levelNum,
    output newLevel,
    output inTransition,
    output levelDone,
    output gameFinished
  );
endinterface

// File: rtl/bg_scroll_level_ctrl.sv
// Per-frame road scroll, distance and level sequencer with timed level transition
// and post-crash stall; every state change is gated by the startOfFrame strobe.
module bg_scroll_level_ctrl #(
  parameter int unsigned LEVEL_LEN    = 4000,
  parameter int unsigned NUM_LEVELS   = 2,
  parameter int unsigned TRANS_FRAMES = 120,
  parameter int unsigned CRASH_FRAMES = 60,
  parameter int unsigned Y_FRAME      = 480
) (
  input  logic                   clk,
  input  logic                   resetN,
  bg_scroll_level_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StCrash,
    StTrans,
    StDone
  } state_e;

  localparam logic [1:0]  LastLevel  = 2'(NUM_LEVELS - 1);
  localparam logic [7:0]  TransLoad  = 8'(TRANS_FRAMES);
  localparam logic [7:0]  CrashLoad  = 8'(CRASH_FRAMES);
  localparam logic [11:0] YFrameW    = 12'(Y_FRAME);

  state_e      state_q, state_d;
  logic [10:0] scroll_q, scroll_d;
  logic [15:0] dist_q, dist_d;
  logic [1:0]  level_q, level_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        crash_pend_q, crash_pend_d;
  logic        level_done_q, level_done_d;
  logic        in_trans_q, in_trans_d;
  logic        finished_q, finished_d;

  logic [11:0] scroll_sum;
  logic [10:0] scroll_next;
  logic [16:0] dist_sum;
  logic [15:0] dist_next;
  logic [7:0]  cnt_dec;
  logic        sof;

  assign sof = bus.startOfFrame;

  // speed never exceeds 7, so one conditional subtract is enough to wrap.
  always_comb begin
    scroll_sum  = {1'b0, scroll_q} + {9'd0, bus.speed};
    scroll_next = (scroll_sum >= YFrameW) ? 11'(scroll_sum - YFrameW) : scroll_sum[10:0];
    dist_sum    = {1'b0, dist_q} + {14'd0, bus.speed};
    dist_next   = dist_sum[16] ? 16'hFFFF : dist_sum[15:0];
    cnt_dec     = cnt_q - 8'd1;
  end

  always_comb begin
    state_d      = state_q;
    scroll_d     = scroll_q;
    dist_d       = dist_q;
    level_d      = level_q;
    cnt_d        = cnt_q;
    level_done_d = 1'b0;
    crash_pend_d = crash_pend_q | bus.crash;

    unique case (state_q)
      StIdle: begin
        scroll_d = '0;
        dist_d   = '0;
        level_d  = '0;
        if (sof && bus.gameStart) begin
          state_d = StRun;
        end
      end

      StRun: begin
        if (sof) begin
          if (crash_pend_q) begin
            // Crash frame freezes scroll, so level completion is not evaluated.
            state_d      = StCrash;
            cnt_d        = CrashLoad;
            crash_pend_d = 1'b0;
          end else begin
            scroll_d = scroll_next;
            dist_d   = dist_next;
            if (32'(dist_next) >= LEVEL_LEN) begin
              state_d      = StTrans;
              cnt_d        = TransLoad;
              level_done_d = 1'b1;
            end
          end
        end
      end

      StCrash: begin
        crash_pend_d = 1'b0;
        if (sof) begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            state_d = StRun;
          end
        end
      end

      StTrans: begin
        crash_pend_d = 1'b0;
        if (sof) begin
          cnt_d = cnt_dec;
          if (cnt_dec == 8'd0) begin
            if (level_q == LastLevel) begin
              state_d = StDone;
            end else begin
              state_d  = StRun;
              level_d  = level_q + 2'd1;
              dist_d   = '0;
              scroll_d = '0;
            end
          end
        end
      end

      StDone: begin
        if (sof && bus.gameStart) begin
          state_d  = StRun;
          level_d  = '0;
          dist_d   = '0;
          scroll_d = '0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    in_trans_d = (state_d == StTrans);
    finished_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (resetN) begin
      state_q      <= StIdle;
      scroll_q     <= '0;
      dist_q       <= '0;
      level_q      <= '0;
      cnt_q        <= '0;
      crash_pend_q <= 1'b0;
      level_done_q <= 1'b0;
      in_trans_q   <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      scroll_q     <= scroll_d;
      dist_q       <= dist_d;
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      crash_pend_q <= crash_pend_d;
      level_done_q <= level_done_d;
      in_trans_q   <= in_trans_d;
      finished_q   <= finished_d;
    end
  end

  assign bus.scrollY      = scroll_q;
  assign bus.distance     = dist_q;
  assign bus.levelNum     = level_q;
  assign bus.newLevel     = level_q[0];
  assign bus.inTransition = in_trans_q;
  assign bus.levelDone    = level_done_q;
  assign bus.gameFinished = finished_q;

endmodule

// File: tb/tb_bg_scroll_level_ctrl.sv
// Directed bench: dut_a uses default parameters (scroll wrap); dut_b uses short levels,
// transitions and crash stalls for the sequencing scenarios.
module tb_bg_scroll_level_ctrl;

  logic clk;
  logic resetN;
  int   total;
  int   bad;

  bg_scroll_level_ctrl_if ifa ();
  bg_scroll_level_ctrl_if ifb ();

  bg_scroll_level_ctrl dut_a (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifa.slave)
  );

  bg_scroll_level_ctrl #(
    .LEVEL_LEN    (20),
    .NUM_LEVELS   (2),
    .TRANS_FRAMES (3),
    .CRASH_FRAMES (2),
    .Y_FRAME      (480)
  ) dut_b (
    .clk    (clk),
    .resetN (resetN),
    .bus    (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One idle cycle, then a one-cycle strobe; returns in the cycle after the strobe.
  task automatic strobe_a();
    @(posedge clk); #1;
    ifa.startOfFrame = 1'b1;
    @(posedge clk); #1;
    ifa.startOfFrame = 1'b0;
  endtask

  task automatic strobe_b();
    @(posedge clk); #1;
    ifb.startOfFrame = 1'b1;
    @(posedge clk); #1;
    ifb.startOfFrame = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    @(posedge clk); #1;
    resetN = 1'b0;
  endtask

  task automatic pulse_crash_b();
    ifb.crash = 1'b1;
    @(posedge clk); #1;
    ifb.crash = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (ifa.scrollY !== 11'd0 || ifa.distance !== 16'd0 || ifa.levelNum !== 2'd0 ||
        ifa.newLevel !== 1'b0 || ifa.inTransition !== 1'b0 || ifa.levelDone !== 1'b0 ||
        ifa.gameFinished !== 1'b0) begin
      bad++;
      $display("FAIL reset_a got scroll=%0d dist=%0d lvl=%0d nl=%b tr=%b ld=%b gf=%b want all 0",
               ifa.scrollY, ifa.distance, ifa.levelNum, ifa.newLevel, ifa.inTransition,
               ifa.levelDone, ifa.gameFinished);
    end
    ifa.speed = 3'd7;
    strobe_a();
    strobe_a();
    total++;
    if (ifa.scrollY !== 11'd0 || ifa.distance !== 16'd0) begin
      bad++;
      $display("FAIL idle_no_scroll got scroll=%0d dist=%0d want 0 0", ifa.scrollY, ifa.distance);
    end
  endtask

  task automatic test_wrap();
    ifa.gameStart = 1'b1;
    strobe_a();
    ifa.gameStart = 1'b0;
    total++;
    if (ifa.scrollY !== 11'd0) begin
      bad++;
      $display("FAIL start_frame_scroll got=%0d want=0", ifa.scrollY);
    end
    for (int i = 0; i < 68; i++) strobe_a();
    total++;
    if (ifa.scrollY !== 11'd476 || ifa.distance !== 16'd476) begin
      bad++;
      $display("FAIL pre_wrap got scroll=%0d dist=%0d want 476 476", ifa.scrollY, ifa.distance);
    end
    strobe_a();
    total++;
    if (ifa.scrollY !== 11'd3 || ifa.distance !== 16'd483) begin
      bad++;
      $display("FAIL wrap got scroll=%0d dist=%0d want 3 483", ifa.scrollY, ifa.distance);
    end
  endtask

  task automatic test_crash();
    do_reset();
    ifb.speed     = 3'd4;
    ifb.gameStart = 1'b1;
    strobe_b();
    ifb.gameStart = 1'b0;
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd4 || ifb.distance !== 16'd4) begin
      bad++;
      $display("FAIL crash_pre got scroll=%0d dist=%0d want 4 4", ifb.scrollY, ifb.distance);
    end
    pulse_crash_b();
    for (int i = 0; i < 3; i++) begin
      strobe_b();
      total++;
      if (ifb.scrollY !== 11'd4 || ifb.distance !== 16'd4) begin
        bad++;
        $display("FAIL crash_hold[%0d] got scroll=%0d dist=%0d want 4 4", i, ifb.scrollY,
                 ifb.distance);
      end
    end
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd8 || ifb.distance !== 16'd8) begin
      bad++;
      $display("FAIL crash_resume got scroll=%0d dist=%0d want 8 8", ifb.scrollY, ifb.distance);
    end
  endtask

  task automatic test_level_step();
    do_reset();
    ifb.speed     = 3'd5;
    ifb.gameStart = 1'b1;
    strobe_b();
    ifb.gameStart = 1'b0;
    for (int i = 0; i < 3; i++) strobe_b();
    total++;
    if (ifb.distance !== 16'd15 || ifb.inTransition !== 1'b0 || ifb.levelDone !== 1'b0) begin
      bad++;
      $display("FAIL pre_level got dist=%0d tr=%b ld=%b want 15 0 0", ifb.distance,
               ifb.inTransition, ifb.levelDone);
    end
    strobe_b();
    total++;
    if (ifb.levelDone !== 1'b1 || ifb.inTransition !== 1'b1 || ifb.distance !== 16'd20) begin
      bad++;
      $display("FAIL level_done got ld=%b tr=%b dist=%0d want 1 1 20", ifb.levelDone,
               ifb.inTransition, ifb.distance);
    end
    @(posedge clk); #1;
    total++;
    if (ifb.levelDone !== 1'b0) begin
      bad++;
      $display("FAIL level_done_pulse got=%b want=0", ifb.levelDone);
    end
    // Crash while transitioning must be discarded.
    pulse_crash_b();
    for (int i = 0; i < 2; i++) begin
      strobe_b();
      total++;
      if (ifb.inTransition !== 1'b1 || ifb.levelNum !== 2'd0 || ifb.scrollY !== 11'd20) begin
        bad++;
        $display("FAIL trans_hold[%0d] got tr=%b lvl=%0d scroll=%0d want 1 0 20", i,
                 ifb.inTransition, ifb.levelNum, ifb.scrollY);
      end
    end
    pulse_crash_b();
    strobe_b();
    total++;
    if (ifb.levelNum !== 2'd1 || ifb.newLevel !== 1'b1 || ifb.distance !== 16'd0 ||
        ifb.scrollY !== 11'd0 || ifb.inTransition !== 1'b0) begin
      bad++;
      $display("FAIL level_step got lvl=%0d nl=%b dist=%0d scroll=%0d tr=%b want 1 1 0 0 0",
               ifb.levelNum, ifb.newLevel, ifb.distance, ifb.scrollY, ifb.inTransition);
    end
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd5 || ifb.distance !== 16'd5) begin
      bad++;
      $display("FAIL no_crash_after_trans got scroll=%0d dist=%0d want 5 5", ifb.scrollY,
               ifb.distance);
    end
  endtask

  task automatic test_finish_restart();
    for (int i = 0; i < 3; i++) strobe_b();
    total++;
    if (ifb.levelDone !== 1'b1 || ifb.inTransition !== 1'b1 || ifb.levelNum !== 2'd1) begin
      bad++;
      $display("FAIL level2_done got ld=%b tr=%b lvl=%0d want 1 1 1", ifb.levelDone,
               ifb.inTransition, ifb.levelNum);
    end
    for (int i = 0; i < 3; i++) strobe_b();
    total++;
    if (ifb.gameFinished !== 1'b1 || ifb.levelNum !== 2'd1 || ifb.inTransition !== 1'b0 ||
        ifb.distance !== 16'd20) begin
      bad++;
      $display("FAIL finished got gf=%b lvl=%0d tr=%b dist=%0d want 1 1 0 20", ifb.gameFinished,
               ifb.levelNum, ifb.inTransition, ifb.distance);
    end
    strobe_b();
    strobe_b();
    total++;
    if (ifb.gameFinished !== 1'b1 || ifb.levelNum !== 2'd1 || ifb.scrollY !== 11'd20) begin
      bad++;
      $display("FAIL done_hold got gf=%b lvl=%0d scroll=%0d want 1 1 20", ifb.gameFinished,
               ifb.levelNum, ifb.scrollY);
    end
    ifb.gameStart = 1'b1;
    strobe_b();
    ifb.gameStart = 1'b0;
    total++;
    if (ifb.gameFinished !== 1'b0 || ifb.levelNum !== 2'd0 || ifb.distance !== 16'd0 ||
        ifb.scrollY !== 11'd0) begin
      bad++;
      $display("FAIL restart got gf=%b lvl=%0d dist=%0d scroll=%0d want 0 0 0 0",
               ifb.gameFinished, ifb.levelNum, ifb.distance, ifb.scrollY);
    end
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd5) begin
      bad++;
      $display("FAIL restart_run got scroll=%0d want 5", ifb.scrollY);
    end
  endtask

  task automatic test_reset_mid_trans();
    do_reset();
    ifb.speed     = 3'd5;
    ifb.gameStart = 1'b1;
    strobe_b();
    ifb.gameStart = 1'b0;
    for (int i = 0; i < 4; i++) strobe_b();
    strobe_b();
    total++;
    if (ifb.inTransition !== 1'b1) begin
      bad++;
      $display("FAIL mid_trans_setup got tr=%b want 1", ifb.inTransition);
    end
    do_reset();
    total++;
    if (ifb.scrollY !== 11'd0 || ifb.distance !== 16'd0 || ifb.levelNum !== 2'd0 ||
        ifb.newLevel !== 1'b0 || ifb.inTransition !== 1'b0 || ifb.levelDone !== 1'b0 ||
        ifb.gameFinished !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_trans got scroll=%0d dist=%0d lvl=%0d tr=%b gf=%b want all 0",
               ifb.scrollY, ifb.distance, ifb.levelNum, ifb.inTransition, ifb.gameFinished);
    end
    strobe_b();
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd0 || ifb.inTransition !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset got scroll=%0d tr=%b want 0 0", ifb.scrollY,
               ifb.inTransition);
    end
    ifb.gameStart = 1'b1;
    strobe_b();
    ifb.gameStart = 1'b0;
    strobe_b();
    total++;
    if (ifb.scrollY !== 11'd5) begin
      bad++;
      $display("FAIL run_after_reset got scroll=%0d want 5", ifb.scrollY);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetN = 1'b1;
    ifa.startOfFrame = 1'b0;
    ifa.gameStart    = 1'b0;
    ifa.crash        = 1'b0;
    ifa.speed        = 3'd0;
    ifb.startOfFrame = 1'b0;
    ifb.gameStart    = 1'b0;
    ifb.crash        = 1'b0;
    ifb.speed        = 3'd0;
    @(posedge clk); #1;

    test_reset();
    test_wrap();
    test_crash();
    test_level_step();
    test_finish_restart();
    test_reset_mid_trans();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_scroll_level_ctrl.md
# bg_scroll_level_ctrl

Frame-rate sequencer for the background renderer: per video frame it advances the road scroll offset, accumulates distance travelled, and steps the game through levels, including a timed level-transition interval and a post-crash stall. It sits between the game-control logic (start, crash, speed) and the background/road drawing blocks, and supplies them with `newLevel`, `levelNum` and `scrollY`. All state changes happen once per frame, on the `startOfFrame` strobe.

## Interface
- `LEVEL_LEN`, 4000: distance (in pixels scrolled) needed to finish a level; range 1..65535.
- `NUM_LEVELS`, 2: number of levels; range 1..4.
- `TRANS_FRAMES`, 120: frames spent in a level transition; range 1..255.
- `CRASH_FRAMES`, 60: frames of forced-zero speed after a crash; range 1..255.
- `Y_FRAME`, 480: wrap modulus for `scrollY`.

- `clk` input 1: system clock.
- `resetN` input 1: synchronous, active-high reset; asserted = 1.
- `startOfFrame` input 1: one-cycle pulse, once per frame.
- `gameStart` input 1: level-sensitive request to start or restart a game.
- `crash` input 1: one-cycle pulse marking a player collision.
- `speed` input 3: pixels to scroll per frame, 0..7.
- `scrollY` output 11: vertical road offset, 0..Y_FRAME-1.
- `distance` output 16: distance travelled in the current level.
- `levelNum` output 2: current level, 0-based.
- `newLevel` output 1: equals `levelNum[0]`; selects the background palette.
- `inTransition` output 1: high while in TRANS.
- `levelDone` output 1: one-cycle pulse on entry to TRANS.
- `gameFinished` output 1: high while in DONE.

## Operation
- States: IDLE, RUN, CRASH, TRANS, DONE. Reset value is IDLE.
- Each frame event happens only on a cycle where `startOfFrame`=1. On all other cycles, state and counters hold. The only exceptions are `crash` capture and reset.
- IDLE:
  - `scrollY`=0, `distance`=0, `levelNum`=0.
  - When `gameStart`=1 on a frame event, go to RUN.
- RUN, on each frame event:
  - `scrollY` ← (`scrollY`+`speed`) mod Y_FRAME. Implement the mod as a single conditional subtract of Y_FRAME, since speed ≤ 7.
  - `distance` ← `distance`+`speed`, saturating at 65535.
  - If the new distance is ≥ LEVEL_LEN, go to TRANS, pulse `levelDone`, and load the frame counter with TRANS_FRAMES.
- CRASH entry:
  - `crash` is a pulse that can land on any cycle. Latch it into a sticky `crashPend` flag.
  - On the next RUN frame event with `crashPend`=1: go to CRASH, load the frame counter with CRASH_FRAMES, and clear `crashPend`. No scroll or distance update occurs on that frame.
- CRASH:
  - Scroll and distance hold.
  - The counter decrements on each frame event. When it reaches 0, return to RUN.
  - Crashes during CRASH are ignored and `crashPend` is cleared.
- TRANS:
  - Scroll and distance hold. `crash` is ignored and `crashPend` is cleared.
  - The counter decrements on each frame event.
  - When it reaches 0 and `levelNum` < NUM_LEVELS-1: `levelNum`+1, `distance` 0, `scrollY` 0, go to RUN.
  - When it reaches 0 and `levelNum` = NUM_LEVELS-1: go to DONE.
- DONE:
  - All outputs hold and `gameFinished`=1.
  - When `gameStart`=1 on a frame event, go to RUN with `levelNum`, `distance` and `scrollY` all 0.
- Priority within one frame event in RUN: pending crash, then level completion. A crash frame performs no distance update, so level completion is not checked on that frame.
- Reset mid-operation: any state goes to IDLE and all counters and flags clear on the next clock edge.

## Timing
- All outputs are registered.
- Frame updates appear on the clock edge that samples `startOfFrame`=1, so they are visible in the cycle after the strobe.
- `levelDone` is high for exactly one clock, in the cycle after the strobe that completes the level.
- The TRANS interval is exactly TRANS_FRAMES frame events long. `levelNum` increments on the TRANS_FRAMES-th strobe after TRANS entry.
- The CRASH interval is exactly CRASH_FRAMES frame events long. Scrolling resumes on the following strobe.
- Reset values:
  - `scrollY` 0, `distance` 0, `levelNum` 0, `newLevel` 0.
  - `inTransition` 0, `levelDone` 0, `gameFinished` 0.

## Test plan
- **Wrap:** reset, start, speed=7, run 69 frames.
  - Required: `scrollY` = 483 mod 480 = 3 and `distance` = 483.
- **Level step:** LEVEL_LEN=20, TRANS_FRAMES=3, speed=5, start.
  - After the 4th RUN strobe: `levelDone` pulses once and `inTransition`=1.
  - 3 strobes later: `levelNum`=1, `newLevel`=1, `distance`=0, `scrollY`=0.
- **Crash:** speed=4 in RUN, pulse `crash` between strobes, CRASH_FRAMES=2.
  - The next 3 strobes leave `scrollY` and `distance` unchanged.
  - The 4th strobe adds 4.
- **Crash during TRANS:** a `crash` pulse while `inTransition`=1.
  - Required: no CRASH entry, either during TRANS or after the return to RUN.
- **Finish and restart:** NUM_LEVELS=2, complete both levels.
  - Required: `gameFinished`=1 and `levelNum`=1 held.
  - With `gameStart`=1 at a strobe: RUN, `levelNum`=0, `gameFinished`=0.
- **Reset mid-TRANS:** assert `resetN`=1 for one cycle.
  - Required: all outputs 0 and state IDLE. Strobes without `gameStart` do not move `scrollY`.
